// File: rtl/adc_conv_sequencer.sv
// Round-robin ADC conversion sequencer: timed start pulse, synchronised EOC
// edge detect, post-conversion holdoff and a watchdog that retries a lost EOC.
module adc_conv_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int START_WIDTH = 2,
    parameter int HOLDOFF     = 3,
    parameter int TIMEOUT     = 64,
    parameter int CNT_W       = 16,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             eoc,
    input  logic             clr_err,
    output logic             start,
    output logic [CH_W-1:0]  ch_sel,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] conv_count
);

    // One shared phase timer covers the start pulse, the watchdog and the holdoff.
    localparam int TMR_MAX_A = (START_WIDTH > TIMEOUT) ? START_WIDTH : TIMEOUT;
    localparam int TMR_MAX   = (TMR_MAX_A > HOLDOFF) ? TMR_MAX_A : HOLDOFF;
    localparam int TMR_W     = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] START_LAST = TMR_W'(START_WIDTH - 1);
    localparam logic [TMR_W-1:0] TO_LAST    = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);
    localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_EOC,
        S_HOLD
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [TMR_W-1:0]   r_tmr;
    logic [TMR_W-1:0]   w_tmr_next;
    logic               w_accept;
    logic               w_timeout;
    logic               w_eoc_rise;

    logic               r_eoc_s1;
    logic               r_eoc_s2;
    logic               r_eoc_s2_q;
    logic               r_start;
    logic [CH_W-1:0]    r_ch_sel;
    logic               r_done;
    logic               r_timeout_err;
    logic [CNT_W-1:0]   r_conv_count;

    assign w_eoc_rise = r_eoc_s2 & ~r_eoc_s2_q;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_tmr_next   = '0;
        w_accept     = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) w_next_state = S_START;
            end
            S_START: begin
                if (r_tmr == START_LAST) w_next_state = S_WAIT_EOC;
                else                     w_tmr_next   = r_tmr + 1'b1;
            end
            S_WAIT_EOC: begin
                // A rise on the last watchdog cycle still counts as a conversion.
                if (w_eoc_rise) begin
                    w_accept     = 1'b1;
                    w_next_state = S_HOLD;
                end else if (r_tmr == TO_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_HOLD;
                end else begin
                    w_tmr_next   = r_tmr + 1'b1;
                end
            end
            S_HOLD: begin
                if (r_tmr == HOLD_LAST) w_next_state = enable ? S_START : S_IDLE;
                else                    w_tmr_next   = r_tmr + 1'b1;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_tmr         <= '0;
            r_eoc_s1      <= 1'b0;
            r_eoc_s2      <= 1'b0;
            r_eoc_s2_q    <= 1'b0;
            r_start       <= 1'b0;
            r_ch_sel      <= '0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_conv_count  <= '0;
        end else begin
            r_eoc_s1      <= eoc;
            r_eoc_s2      <= r_eoc_s1;
            r_eoc_s2_q    <= r_eoc_s2;
            r_state       <= w_next_state;
            r_tmr         <= w_tmr_next;
            r_start       <= (w_next_state == S_START);
            r_done        <= w_accept;
            if (w_accept) begin
                r_conv_count <= r_conv_count + 1'b1;
                r_ch_sel     <= (r_ch_sel == CH_LAST) ? '0 : r_ch_sel + 1'b1;
            end
            if (w_timeout)    r_timeout_err <= 1'b1;
            else if (clr_err) r_timeout_err <= 1'b0;
        end
    end

    assign start       = r_start;
    assign ch_sel      = r_ch_sel;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign timeout_err = r_timeout_err;
    assign conv_count  = r_conv_count;

endmodule

// File: doc/adc_conv_sequencer.md
Name: adc_conv_sequencer

Overview:
- Parametrised successor to the single-shot EOC-to-new-start logic in the ADC capture path.
- Issues start-of-conversion pulses of configurable width and walks round-robin over NUM_CH analog channels.
- Detects end-of-conversion from an asynchronous eoc line and enforces a holdoff between conversions.
- A watchdog retries a conversion whose EOC never arrives. Sits between the sample-and-hold/mux control and the ADC.

Parameters:
- NUM_CH, 4: number of channels in the round-robin (>=1); CH_W = max(1, clog2(NUM_CH)).
- START_WIDTH, 2: start pulse length in clk_in cycles (>=1).
- HOLDOFF, 3: idle cycles between accepted EOC/timeout and next start (>=0).
- TIMEOUT, 64: max cycles in WAIT_EOC before retry (>=2).
- CNT_W, 16: width of conversion counter.

Ports:
- clk_in  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  run request, synchronous level
- eoc  input  1  end-of-conversion from ADC, asynchronous, active-high level/edge
- clr_err  input  1  synchronous clear of timeout_err
- start  output  1  start-of-conversion pulse, registered
- ch_sel  output  CH_W  channel under conversion, registered
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse per accepted EOC
- timeout_err  output  1  sticky watchdog flag
- conv_count  output  CNT_W  accepted conversions, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, rst_n=0): state IDLE; start=0, ch_sel=0, busy=0, done=0, timeout_err=0, conv_count=0; synchroniser flops and all counters cleared. Reset mid-conversion aborts immediately with no done pulse.
- EOC path: 2-FF synchroniser (s1, s2) followed by rising-edge detect (rise = s2 & ~s2_q). eoc rising before edge E0 makes rise true between E1 and E2; the FSM acts on it at E2.
- IDLE: enable sampled high at edge k -> START from k. start=1 during cycles k..k+START_WIDTH-1.
- START: hold start=1 for exactly START_WIDTH cycles, then WAIT_EOC with start=0. Any rise during START is discarded.
- WAIT_EOC:
  - Timeout counter counts from 0.
  - On rise: done=1 for one cycle, conv_count+1, ch_sel advances (NUM_CH-1 wraps to 0), go to HOLD.
  - Counter reaches TIMEOUT-1 without rise: timeout_err set, ch_sel unchanged (retry same channel), no done, no count, go to HOLD.
  - Rise and timeout in the same cycle: rise wins.
- HOLD: stay HOLDOFF cycles. Then START if enable=1, else IDLE. HOLDOFF=0 goes straight to the START/IDLE decision on the next edge.
- enable low mid-conversion: current conversion completes (including HOLD), then IDLE. ch_sel is retained in IDLE; it is not reset to 0.
- ch_sel is stable from START through WAIT_EOC and changes only on the edge that accepts EOC.
- timeout_err: cleared by clr_err. A set and clr_err in the same cycle leaves it set.
- NUM_CH=1: ch_sel is constantly 0.
- busy = (state != IDLE).

Test Plan:
- Reset then enable=1, eoc pulsed high 3 cycles starting 5 cycles after the start fall, defaults -> start high exactly 2 cycles; done pulses 3 edges after eoc rises; ch_sel 0->1; conv_count=1; next start after 3 holdoff cycles.
- Continuous run of 9 conversions with prompt eoc -> ch_sel sequence 0,1,2,3,0,1,2,3,0,1; conv_count=9; done count=9; timeout_err=0.
- No eoc after start, TIMEOUT=16 -> timeout_err=1 after 16 WAIT_EOC cycles; ch_sel stays 0; start re-issued after holdoff; conv_count=0. clr_err pulse -> timeout_err=0.
- eoc pulse during START, none afterwards -> ignored; no done; timeout path taken. eoc rise timed to coincide with the final timeout cycle -> done=1, timeout_err stays 0.
- enable dropped during WAIT_EOC, then eoc -> done, conv_count+1, HOLD, then IDLE with busy=0 and ch_sel retained at 1. Re-enable -> converts channel 1.
- rst_n asserted mid-WAIT_EOC -> all outputs 0 immediately (asynchronously), no done pulse. Release with enable=1 -> starts on channel 0.
